// File: rtl/aq_axis_djpeg_pixout.sv
// JPEG decoder pixel output stage: FIFO-buffered AXI4-Stream video master.
// Optional raster check/counters enabled by AQ_DJPEG_PIXOUT_CHECK_EN.
module aq_axis_djpeg_pixout #(
  parameter int FIFO_AW = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        LOGIC_RST,
  input  logic        DEC_SIZE_VALID,
  input  logic [15:0] DEC_WIDTH,
  input  logic [15:0] DEC_HEIGHT,
  input  logic        DEC_PIX_VALID,
  output logic        DEC_PIX_READY,
  input  logic [15:0] DEC_PIX_X,
  input  logic [15:0] DEC_PIX_Y,
  input  logic [23:0] DEC_PIX_DATA,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [15:0] WIDTH,
  output logic [15:0] HEIGHT,
  output logic [15:0] PIXELX,
  output logic [15:0] PIXELY,
  output logic        LOGIC_IDLE,
  output logic        ERROR
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic               rst;
  logic [57:0]        mem [DEPTH];
  logic [57:0]        head;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               frame_start;
  logic [15:0]        cur_x;
  logic [15:0]        cur_y;
  logic               tuser;
  logic               tlast;
  logic               last_pix;

  assign rst   = ~ARESETN | LOGIC_RST;
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign DEC_PIX_READY = (state == S_RUN) & ~full & ~LOGIC_RST;
  assign push = DEC_PIX_VALID & DEC_PIX_READY;
  assign pop  = ~empty & M_AXIS_TREADY;

  assign frame_start = (state == S_IDLE) & DEC_SIZE_VALID
                     & (|DEC_WIDTH) & (|DEC_HEIGHT);

`ifdef AQ_DJPEG_PIXOUT_CHECK_EN
  logic [15:0] x_exp;
  logic [15:0] y_exp;
  logic        err_q;

  assign cur_x = x_exp;
  assign cur_y = y_exp;
  assign ERROR = err_q;

  always_ff @(posedge ACLK) begin
    if (rst) begin
      x_exp <= '0;
      y_exp <= '0;
      err_q <= 1'b0;
    end else if (frame_start) begin
      x_exp <= '0;
      y_exp <= '0;
      err_q <= 1'b0;
    end else if (push) begin
      if (x_exp == WIDTH - 16'd1) begin
        x_exp <= '0;
        y_exp <= y_exp + 16'd1;
      end else begin
        x_exp <= x_exp + 16'd1;
      end
      if ((DEC_PIX_X != x_exp) || (DEC_PIX_Y != y_exp))
        err_q <= 1'b1;
    end
  end
`else
  assign cur_x = DEC_PIX_X;
  assign cur_y = DEC_PIX_Y;
  assign ERROR = 1'b0;
`endif

  assign tuser    = (cur_x == 16'd0) && (cur_y == 16'd0);
  assign tlast    = (cur_x == WIDTH - 16'd1);
  assign last_pix = tlast && (cur_y == HEIGHT - 16'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (frame_start) state_nx = S_RUN;
      S_RUN:   if (push && last_pix) state_nx = S_DRAIN;
      // leave as the final beat is taken so idle follows it by one cycle
      S_DRAIN: if (empty || (count == CNT_ONE && pop)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= {cur_y, cur_x, tuser, tlast, DEC_PIX_DATA};
  end

  always_ff @(posedge ACLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (rst) begin
      WIDTH  <= '0;
      HEIGHT <= '0;
      PIXELX <= '0;
      PIXELY <= '0;
    end else if (frame_start) begin
      WIDTH  <= DEC_WIDTH;
      HEIGHT <= DEC_HEIGHT;
      PIXELX <= '0;
      PIXELY <= '0;
    end else if (pop) begin
      PIXELX <= head[41:26];
      PIXELY <= head[57:42];
    end
  end

  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TDATA  = empty ? 32'h0 : {8'h00, head[23:0]};
  assign M_AXIS_TUSER  = ~empty & head[25];
  assign M_AXIS_TLAST  = ~empty & head[24];
  assign LOGIC_IDLE    = (state == S_IDLE);

endmodule

// File: tb/tb_aq_axis_djpeg_pixout.sv
// Bench for aq_axis_djpeg_pixout: random pixel data and handshakes
// against a raster-order frame model held in queues.
module tb_aq_axis_djpeg_pixout;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        LOGIC_RST;
  logic        DEC_SIZE_VALID;
  logic [15:0] DEC_WIDTH;
  logic [15:0] DEC_HEIGHT;
  logic        DEC_PIX_VALID;
  logic        DEC_PIX_READY;
  logic [15:0] DEC_PIX_X;
  logic [15:0] DEC_PIX_Y;
  logic [23:0] DEC_PIX_DATA;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TUSER;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [15:0] WIDTH;
  logic [15:0] HEIGHT;
  logic [15:0] PIXELX;
  logic [15:0] PIXELY;
  logic        LOGIC_IDLE;
  logic        ERROR;

  aq_axis_djpeg_pixout #(.FIFO_AW(4)) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .LOGIC_RST      (LOGIC_RST),
    .DEC_SIZE_VALID (DEC_SIZE_VALID),
    .DEC_WIDTH      (DEC_WIDTH),
    .DEC_HEIGHT     (DEC_HEIGHT),
    .DEC_PIX_VALID  (DEC_PIX_VALID),
    .DEC_PIX_READY  (DEC_PIX_READY),
    .DEC_PIX_X      (DEC_PIX_X),
    .DEC_PIX_Y      (DEC_PIX_Y),
    .DEC_PIX_DATA   (DEC_PIX_DATA),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TUSER   (M_AXIS_TUSER),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .WIDTH          (WIDTH),
    .HEIGHT         (HEIGHT),
    .PIXELX         (PIXELX),
    .PIXELY         (PIXELY),
    .LOGIC_IDLE     (LOGIC_IDLE),
    .ERROR          (ERROR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [23:0] d;
  } pix_t;

  typedef struct {
    logic        u;
    logic        l;
    logic [31:0] d;
  } beat_t;

  pix_t  src[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    acc;
  int    got;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        pix_t  p;
        beat_t b;
        p.x = 16'(x);
        p.y = 16'(y);
        p.d = 24'($urandom);
        src.push_back(p);
        b.u = (x == 0 && y == 0);
        b.l = (x == w - 1);
        b.d = {8'h00, p.d};
        exp_q.push_back(b);
      end
  endtask

  task automatic start_frame(input int w, input int h);
    @(negedge ACLK);
    DEC_SIZE_VALID = 1'b1;
    DEC_WIDTH = 16'(w);
    DEC_HEIGHT = 16'(h);
    @(negedge ACLK);
    DEC_SIZE_VALID = 1'b0;
    #1;
    chk("start_width", WIDTH, 64'(w));
    chk("start_height", HEIGHT, 64'(h));
    chk("start_busy", LOGIC_IDLE, 0);
    chk("start_ready", DEC_PIX_READY, 1);
  endtask

  task automatic pump(input int maxc, input int stall, input bit gaps,
                      input int resize_at);
    int cyc = 0;
    bit idle_chk = 0;
    acc = 0;
    got = 0;
    while ((src.size() > 0 || exp_q.size() > 0 || idle_chk) && cyc < maxc) begin
      @(negedge ACLK);
      if (idle_chk) begin
        chk("idle_after_last", LOGIC_IDLE, 1);
        idle_chk = 0;
      end
      DEC_SIZE_VALID = (cyc == resize_at);
      DEC_WIDTH = 16'd9;
      DEC_HEIGHT = 16'd9;
      DEC_PIX_VALID = (src.size() > 0) && (!gaps || $urandom_range(3) != 0);
      if (src.size() > 0) begin
        DEC_PIX_X = src[0].x;
        DEC_PIX_Y = src[0].y;
        DEC_PIX_DATA = src[0].d;
      end
      M_AXIS_TREADY = (cyc >= stall) && (!gaps || $urandom_range(3) != 0);
      #1;
      if (stall > 0 && cyc == stall - 1) begin
        chk("accepts_while_stalled", 64'(acc), 16);
        chk("ready_low_when_full", DEC_PIX_READY, 0);
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("tdata", M_AXIS_TDATA, 64'(b.d));
          chk("tuser", M_AXIS_TUSER, 64'(b.u));
          chk("tlast", M_AXIS_TLAST, 64'(b.l));
          got++;
          if (exp_q.size() == 0 && src.size() == 0) idle_chk = 1;
        end
      end
      if (DEC_PIX_VALID && DEC_PIX_READY) begin
        void'(src.pop_front());
        acc++;
      end
      cyc++;
    end
    @(negedge ACLK);
    DEC_PIX_VALID = 1'b0;
    DEC_SIZE_VALID = 1'b0;
    M_AXIS_TREADY = 1'b0;
    chk("pump_timeout", 64'(cyc >= maxc), 0);
  endtask

  initial begin
    ARESETN = 1'b0;
    LOGIC_RST = 1'b0;
    DEC_SIZE_VALID = 1'b0;
    DEC_WIDTH = '0;
    DEC_HEIGHT = '0;
    DEC_PIX_VALID = 1'b0;
    DEC_PIX_X = '0;
    DEC_PIX_Y = '0;
    DEC_PIX_DATA = '0;
    M_AXIS_TREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("rst_ready", DEC_PIX_READY, 0);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_tuser", M_AXIS_TUSER, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_wh", {WIDTH, HEIGHT}, 0);
    chk("rst_pxy", {PIXELX, PIXELY}, 0);
    chk("rst_idle", LOGIC_IDLE, 1);
    chk("rst_error", ERROR, 0);

    // zero-sized frames are ignored
    @(negedge ACLK);
    DEC_SIZE_VALID = 1'b1;
    DEC_WIDTH = 16'd0;
    DEC_HEIGHT = 16'd5;
    @(negedge ACLK);
    DEC_WIDTH = 16'd5;
    DEC_HEIGHT = 16'd0;
    @(negedge ACLK);
    DEC_SIZE_VALID = 1'b0;
    #1;
    chk("zero_idle", LOGIC_IDLE, 1);
    chk("zero_ready", DEC_PIX_READY, 0);
    chk("zero_width", WIDTH, 0);

    // 4x2 with resize attempt mid-frame
    start_frame(4, 2);
    load_frame(4, 2);
    pump(200, 0, 0, 3);
    chk("f4x2_beats", 64'(got), 8);
    chk("f4x2_width_kept", WIDTH, 4);
    chk("f4x2_pixelx", PIXELX, 3);
    chk("f4x2_pixely", PIXELY, 1);
    chk("f4x2_idle", LOGIC_IDLE, 1);

    // 16x16 with downstream stalled for 40 cycles
    start_frame(16, 16);
    load_frame(16, 16);
    pump(2000, 40, 0, -1);
    chk("f16_beats", 64'(got), 256);
    chk("f16_pixelxy", {PIXELX, PIXELY}, {16'd15, 16'd15});

    // width 1
    start_frame(1, 3);
    load_frame(1, 3);
    pump(200, 0, 0, -1);
    chk("f1x3_beats", 64'(got), 3);

    // random handshakes
    start_frame(5, 3);
    load_frame(5, 3);
    pump(1000, 0, 1, -1);
    chk("f5x3_beats", 64'(got), 15);
    chk("f5x3_pixelxy", {PIXELX, PIXELY}, {16'd4, 16'd2});

    // soft reset with 5 pixels buffered
    start_frame(4, 4);
    load_frame(4, 4);
    acc = 0;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      @(negedge ACLK);
      DEC_PIX_VALID = 1'b1;
      DEC_PIX_X = src[0].x;
      DEC_PIX_Y = src[0].y;
      DEC_PIX_DATA = src[0].d;
      #1;
      if (DEC_PIX_READY) begin
        void'(src.pop_front());
        acc++;
      end
    end
    @(negedge ACLK);
    DEC_PIX_X = src[0].x;
    DEC_PIX_Y = src[0].y;
    DEC_PIX_DATA = src[0].d;
    LOGIC_RST = 1'b1;
    #1;
    chk("lrst_buffered", M_AXIS_TVALID, 1);
    chk("lrst_ready_gated", DEC_PIX_READY, 0);
    @(negedge ACLK);
    LOGIC_RST = 1'b0;
    DEC_PIX_VALID = 1'b0;
    #1;
    chk("lrst_tvalid", M_AXIS_TVALID, 0);
    chk("lrst_tdata", M_AXIS_TDATA, 0);
    chk("lrst_width", WIDTH, 0);
    chk("lrst_idle", LOGIC_IDLE, 1);
    src.delete();
    exp_q.delete();

    start_frame(2, 2);
    load_frame(2, 2);
    pump(200, 0, 1, -1);
    chk("f2x2_beats", 64'(got), 4);

`ifdef AQ_DJPEG_PIXOUT_CHECK_EN
    start_frame(3, 1);
    load_frame(3, 1);
    src[1].x = 16'd2;
    pump(200, 0, 0, -1);
    chk("chk_error_set", ERROR, 1);
    chk("chk_pixelx", PIXELX, 2);
    start_frame(2, 1);
    chk("chk_error_clear", ERROR, 0);
    load_frame(2, 1);
    pump(200, 0, 0, -1);
`else
    chk("error_tied_low", ERROR, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
